// File: rtl/fsbm_search_ctrl.sv
// Full-search block-matching sequencer: walks every candidate displacement in raster order,
// issues pixel read addresses, and tracks the minimum SAD. Optional macro: FSBM_EARLY_TERM_EN.
module fsbm_search_ctrl #(
  parameter int BLK_N   = 16,
  parameter int RANGE_P = 8,
  parameter int SAD_W   = 16,
  localparam int CW = $clog2(BLK_N),
  localparam int RW = $clog2(BLK_N + 2*RANGE_P),
  localparam int MW = $clog2(2*RANGE_P) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [CW-1:0]    cur_x,
  output logic [CW-1:0]    cur_y,
  output logic [RW-1:0]    ref_x,
  output logic [RW-1:0]    ref_y,
  output logic             acc_clr,
  output logic             cand_last,
  input  logic [SAD_W-1:0] sad_in,
  input  logic             sad_valid,
  output logic [MW-1:0]    mv_x,
  output logic [MW-1:0]    mv_y,
  output logic [SAD_W-1:0] min_sad
`ifdef FSBM_EARLY_TERM_EN
  ,
  input  logic [SAD_W-1:0] sad_part,
  input  logic             sad_part_vld
`endif
);

  localparam int DW = MW - 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_CMP, S_DONE} state_t;
  state_t state, state_nx;

  logic [DW-1:0]    dxi, dyi, dx_nx, dy_nx;
  logic [CW-1:0]    cx_nx, cy_nx;
  logic [SAD_W-1:0] sad_q;
  logic             pix_last, cand_end, abort, step_cand;

  assign pix_last = (cur_x == CW'(BLK_N-1)) && (cur_y == CW'(BLK_N-1));
  assign cand_end = (dxi == DW'(2*RANGE_P-1)) && (dyi == DW'(2*RANGE_P-1));

`ifdef FSBM_EARLY_TERM_EN
  // The first candidate always runs to completion so min_sad holds a real SAD before any abort.
  assign abort = (state == S_SCAN) && !((dxi == '0) && (dyi == '0)) &&
                 sad_part_vld && (sad_part >= min_sad);
`else
  assign abort = 1'b0;
`endif

  assign step_cand = (state == S_CMP) || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // sad_valid is a valid-only handshake: there is no ready, and it is honoured only in WAIT.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_SCAN;
      S_SCAN: begin
        if (abort)         state_nx = cand_end ? S_DONE : S_SCAN;
        else if (pix_last) state_nx = S_WAIT;
      end
      S_WAIT: if (sad_valid) state_nx = S_CMP;
      S_CMP:  state_nx = cand_end ? S_DONE : S_SCAN;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cx_nx = cur_x;
    cy_nx = cur_y;
    dx_nx = dxi;
    dy_nx = dyi;
    if (state == S_IDLE && start) begin
      cx_nx = '0;
      cy_nx = '0;
      dx_nx = '0;
      dy_nx = '0;
    end else if (step_cand) begin
      cx_nx = '0;
      cy_nx = '0;
      if (dxi == DW'(2*RANGE_P-1)) begin
        dx_nx = '0;
        dy_nx = dyi + DW'(1);
      end else begin
        dx_nx = dxi + DW'(1);
      end
    end else if (state == S_SCAN && !pix_last) begin
      if (cur_x == CW'(BLK_N-1)) begin
        cx_nx = '0;
        cy_nx = cur_y + CW'(1);
      end else begin
        cx_nx = cur_x + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dxi       <= '0;
      dyi       <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      ref_x     <= '0;
      ref_y     <= '0;
      rd_en     <= 1'b0;
      acc_clr   <= 1'b0;
      cand_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sad_q     <= '0;
      min_sad   <= '0;
      mv_x      <= '0;
      mv_y      <= '0;
    end else begin
      dxi       <= dx_nx;
      dyi       <= dy_nx;
      cur_x     <= cx_nx;
      cur_y     <= cy_nx;
      ref_x     <= RW'(dx_nx) + RW'(cx_nx);
      ref_y     <= RW'(dy_nx) + RW'(cy_nx);
      rd_en     <= (state_nx == S_SCAN);
      acc_clr   <= (state_nx == S_SCAN) && (cx_nx == '0) && (cy_nx == '0);
      cand_last <= (state_nx == S_SCAN) && (cx_nx == CW'(BLK_N-1)) && (cy_nx == CW'(BLK_N-1));
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_DONE);
      if (state == S_WAIT && sad_valid) sad_q <= sad_in;
      if (state == S_IDLE && start) begin
        min_sad <= '1;
        mv_x    <= '0;
        mv_y    <= '0;
      end else if (state == S_CMP && sad_q < min_sad) begin
        // Strict compare: a tie keeps the earlier raster candidate.
        min_sad <= sad_q;
        mv_x    <= MW'(dxi) - MW'(RANGE_P);
        mv_y    <= MW'(dyi) - MW'(RANGE_P);
      end
    end
  end

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// Bench for fsbm_search_ctrl: W=2 datapath model, scoreboard of expected search results,
// sequence counters per run, reset and mid-run reset scenarios.
module tb_fsbm_search_ctrl;
  localparam int BLK_N = 4, RANGE_P = 2, SAD_W = 16;
  localparam int CW = 2, RW = 3, MW = 3;
  localparam int RW_EXP = MW + MW + SAD_W;

  logic             clk = 1'b0;
  logic             rst_n, start, sad_valid;
  logic [SAD_W-1:0] sad_in;
  logic             busy, done, rd_en, acc_clr, cand_last;
  logic [CW-1:0]    cur_x, cur_y;
  logic [RW-1:0]    ref_x, ref_y;
  logic [MW-1:0]    mv_x, mv_y;
  logic [SAD_W-1:0] min_sad;
`ifdef FSBM_EARLY_TERM_EN
  logic [SAD_W-1:0] sad_part;
  logic             sad_part_vld;
`endif

  fsbm_search_ctrl #(.BLK_N(BLK_N), .RANGE_P(RANGE_P), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .cur_x(cur_x), .cur_y(cur_y), .ref_x(ref_x), .ref_y(ref_y),
    .acc_clr(acc_clr), .cand_last(cand_last), .sad_in(sad_in), .sad_valid(sad_valid),
    .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad)
`ifdef FSBM_EARLY_TERM_EN
    , .sad_part(sad_part), .sad_part_vld(sad_part_vld)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [RW_EXP-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SAD table per scenario: mode 0 = unique minimum at (3,1), mode 1 = all equal.
  function automatic logic [SAD_W-1:0] sad_of(input int m, input int dx, input int dy);
    if (m == 0) return (dx == 3 && dy == 1) ? 16'd7 : 16'd100;
    return 16'd50;
  endfunction

  function automatic logic [RW_EXP-1:0] exp_result(input int m);
    logic [SAD_W-1:0] best;
    logic [SAD_W-1:0] s;
    logic [MW-1:0] ex, ey;
    int bx, by;
    best = '1; bx = 0; by = 0;
    for (int dy = 0; dy < 2*RANGE_P; dy++)
      for (int dx = 0; dx < 2*RANGE_P; dx++) begin
        s = sad_of(m, dx, dy);
        if (s < best) begin best = s; bx = dx; by = dy; end
      end
    ex = MW'(bx - RANGE_P);
    ey = MW'(by - RANGE_P);
    return {ex, ey, best};
  endfunction

  // Datapath model: SAD of a candidate returned two cycles after its last pixel.
  int mode = 0;
  bit inject = 0;
  logic v1, v2;
  logic [SAD_W-1:0] s1, s2;
  int pix, mdx, mdy;
  always @(negedge clk) begin
    if (!rst_n) begin
      v1 = 0; v2 = 0; s1 = '0; s2 = '0; pix = 0; mdx = 0; mdy = 0;
      sad_valid = 0; sad_in = '0;
`ifdef FSBM_EARLY_TERM_EN
      sad_part = '0; sad_part_vld = 0;
`endif
    end else begin
      sad_valid = v2;
      sad_in = v2 ? s2 : '0;
      v2 = v1; s2 = s1;
      if (rd_en) begin
        if (acc_clr) begin pix = 1; mdx = int'(ref_x); mdy = int'(ref_y); end
        else pix++;
      end
`ifdef FSBM_EARLY_TERM_EN
      sad_part_vld = rd_en;
      sad_part = (SAD_W'(pix*10) < sad_of(mode, mdx, mdy)) ? SAD_W'(pix*10) : sad_of(mode, mdx, mdy);
`endif
      v1 = rd_en && cand_last;
      s1 = sad_of(mode, mdx, mdy);
      if (inject && rd_en && $urandom_range(0, 2) == 0) begin
        sad_valid = 1; sad_in = '0;
      end
    end
  end

  // Monitor: per-run counters and result scoreboard.
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_tot = 0;
  int run_rd = 0, run_clr = 0, run_last = 0, run_done = 0, run_abort_clr = 0, run_bad_wait = 0;
  logic [RW-1:0] first_rx, first_ry, p16_rx, p16_ry, c5_rx, c5_ry;
  logic prev_rd = 0, prev_last = 0;
  logic [RW_EXP-1:0] e;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (start && !busy) begin
        start_cyc = cyc;
        run_rd = 0; run_clr = 0; run_last = 0; run_done = 0; run_abort_clr = 0; run_bad_wait = 0;
      end
      if (rd_en) begin
        run_rd++;
        if (run_rd == 1)  begin first_rx = ref_x; first_ry = ref_y; end
        if (run_rd == 16) begin p16_rx = ref_x; p16_ry = ref_y; end
      end
      if (acc_clr) begin
        run_clr++;
        if (run_clr == 6) begin c5_rx = ref_x; c5_ry = ref_y; end
        if (prev_rd && !prev_last) run_abort_clr++;
      end
      if (cand_last) run_last++;
      if (prev_rd && !prev_last && !rd_en && !done) run_bad_wait++;
      if (done) begin
        run_done++; done_tot++; done_cyc = cyc;
        if (exp_q.size() == 0) check("done_spurious", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("mv_x", 32'(mv_x), 32'(e[RW_EXP-1 -: MW]));
          check("mv_y", 32'(mv_y), 32'(e[SAD_W +: MW]));
          check("min_sad", 32'(min_sad), 32'(e[SAD_W-1:0]));
        end
      end
      prev_rd = rd_en; prev_last = cand_last;
    end else begin
      prev_rd = 0; prev_last = 0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0 = done_tot; seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_tot > d0) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic run_search(input int m, input bit inj);
    mode = m; inject = inj;
    exp_q.push_back(exp_result(m));
    pulse_start();
    wait_done(2000);
    repeat (3) @(posedge clk);
    check("done_pulses", 32'(run_done), 32'd1);
    inject = 0;
  endtask

  initial begin
    rst_n = 0; start = 1;
    repeat (3) @(negedge clk) check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_acc_clr", 32'(acc_clr), 32'd0);
    check("rst_cand_last", 32'(cand_last), 32'd0);
    check("rst_cur", 32'({cur_x, cur_y}), 32'd0);
    check("rst_ref", 32'({ref_x, ref_y}), 32'd0);
    check("rst_mv", 32'({mv_x, mv_y}), 32'd0);
    check("rst_min_sad", 32'(min_sad), 32'd0);
    start = 0; rst_n = 1;
    repeat (4) @(negedge clk) check("idle_busy", 32'({busy, rd_en}), 32'd0);

    // Unique minimum with latency check.
    run_search(0, 0);
`ifndef FSBM_EARLY_TERM_EN
    check("done_latency", 32'(done_cyc - start_cyc), 32'd305);
`endif

    // Ties keep the first candidate.
    run_search(1, 0);

    // Sequence with spurious sad_valid during SCAN.
    run_search(0, 1);
    check("acc_clr_cnt", 32'(run_clr), 32'd16);
    check("first_ref", 32'({first_rx, first_ry}), 32'd0);
    check("pix16_ref", 32'({p16_rx, p16_ry}), 32'({3'd3, 3'd3}));
    check("cand5_ref", 32'({c5_rx, c5_ry}), 32'({3'd1, 3'd1}));
`ifdef FSBM_EARLY_TERM_EN
    check("rd_en_below_256", 32'(run_rd < 256), 32'd1);
    check("abort_then_clr", 32'(run_abort_clr > 0), 32'd1);
    check("abort_no_wait", 32'(run_bad_wait), 32'd0);
`else
    check("rd_en_cnt", 32'(run_rd), 32'd256);
    check("cand_last_cnt", 32'(run_last), 32'd16);
    check("no_early_wait", 32'(run_bad_wait), 32'd0);
`endif

    // Mid-run reset, then a clean rerun.
    mode = 0;
    exp_q.push_back(exp_result(0));
    pulse_start();
    repeat (39) @(posedge clk);
    #1 rst_n = 0;
    #1 check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(rd_en), 32'd0);
    check("midrst_min_sad", 32'(min_sad), 32'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk) rst_n = 1;
    run_search(0, 0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fsbm_search_ctrl.md
# fsbm_search_ctrl

Sequencing controller for the full-search block-matching engine. It takes one `start` and then scans every candidate displacement of the search window in raster order. For each candidate it drives the block-pixel and window-pixel read addresses and the SAD accumulator controls. It then compares each returned SAD against the running minimum and reports the best motion vector with a one-cycle `done`. It sits between the top-level control and the pixel memories / PE accumulator datapath.

## Interface
- `BLK_N`, 16: block edge in pixels; power of two, at least 2; `CW = $clog2(BLK_N)`.
- `RANGE_P`, 8: search range; displacement runs from -RANGE_P to RANGE_P-1 per axis; `RW = $clog2(BLK_N+2*RANGE_P)`, `MW = $clog2(2*RANGE_P)+1`.
- `SAD_W`, 16: SAD width; must hold `BLK_N*BLK_N*255`.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: begin a search; sampled only in IDLE.
- `busy` output, 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` output, 1: one-cycle pulse when the result is final.
- `rd_en` output, 1: pixel pair read strobe.
- `cur_x`, `cur_y` output, CW: current-block pixel coordinate.
- `ref_x`, `ref_y` output, RW: search-window pixel coordinate.
- `acc_clr` output, 1: accumulator restarts with this pixel.
- `cand_last` output, 1: this pixel is the last of the candidate.
- `sad_in` input, SAD_W: completed candidate SAD.
- `sad_valid` input, 1: `sad_in` is valid; honoured in WAIT only.
- `mv_x`, `mv_y` output, MW: best displacement, two's complement.
- `min_sad` output, SAD_W: SAD of the best candidate.
- `sad_part` input, SAD_W: running partial SAD. Present only with `FSBM_EARLY_TERM_EN`.
- `sad_part_vld` input, 1: `sad_part` is valid. Present only with `FSBM_EARLY_TERM_EN`.

## Operation
- States are IDLE, SCAN, WAIT, CMP and DONE.
- **IDLE:**
  - `start` moves the controller to SCAN.
  - Candidate indices `dxi` and `dyi` go to 0, the pixel counters go to 0, and `min_sad` loads all-ones.
  - `start` outside IDLE is ignored.
- **SCAN:**
  - One pixel is issued per cycle with `rd_en`=1, raster order, `cur_x` fastest.
  - `ref_x = dxi + cur_x` and `ref_y = dyi + cur_y`.
  - `acc_clr`=1 with pixel (0,0); `cand_last`=1 with pixel (BLK_N-1, BLK_N-1).
  - After the last pixel the state goes to WAIT.
- **WAIT:** `rd_en`=0; the controller stays in WAIT until `sad_valid`=1, then latches `sad_in` and goes to CMP.
- **CMP** (one cycle):
  - If `sad_in < min_sad`, which is a strict comparison, `min_sad`, `mv_x` and `mv_y` update, with `mv_x = dxi - RANGE_P` and `mv_y = dyi - RANGE_P`.
  - Ties keep the earlier raster candidate.
  - The candidate then advances: `dxi` increments; when `dxi` wraps from 2P-1 to 0, `dyi` increments.
  - After candidate (2P-1, 2P-1) the state goes to DONE; otherwise it goes to SCAN.
- **DONE:** `done`=1 for one cycle, then the state returns to IDLE. `mv_x`, `mv_y` and `min_sad` hold until the next accepted `start`.
- `sad_valid` in any state other than WAIT is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `acc_clr`, `cand_last`, `cur_*`, `ref_*`, `mv_x`, `mv_y` and `min_sad` are all 0.
- `start` high in cycle t means the first `rd_en` appears in cycle t+1.
- All outputs are registered.
- Cycles per candidate are `BLK_N*BLK_N` (SCAN) + W (WAIT, at least 1, until `sad_valid` is seen) + 1 (CMP).
- With a fixed datapath latency W, the search takes `(2P)^2*(N^2+W+1)` cycles from the first `rd_en` to the last CMP, plus one DONE cycle.
- Reset asserted mid-operation returns the block to IDLE immediately, asynchronously, with all outputs at their reset values. No partial result is retained.

## Configuration
- Macro: `FSBM_EARLY_TERM_EN`.
- **Defined:**
  - The `sad_part` and `sad_part_vld` ports exist.
  - In SCAN, for any candidate except the first, `sad_part_vld && sad_part >= min_sad` aborts the candidate.
  - The pixel issued in that cycle is discarded; WAIT and CMP are skipped and `min_sad` is unchanged.
  - The next cycle starts the next candidate in SCAN with `acc_clr`, or goes to DONE if the aborted candidate was the last one.
  - Results must equal those of the non-terminating search.
- **Undefined:** the ports are absent and every candidate scans all `BLK_N*BLK_N` pixels.

## Test plan
- All bench scenarios use BLK_N=4, RANGE_P=2, SAD_W=16 (16 candidates), with a datapath model of latency W=2.
- **Reset:** hold `rst_n`=0 with `start`=1 → every output is 0 and no `rd_en` appears; release reset with `start`=0 → the block stays idle.
- **Unique minimum:** the model returns SAD 100 for every candidate except (`dxi`=3, `dyi`=1), which returns 7 → `mv_x`=+1, `mv_y`=-1, `min_sad`=7, exactly one `done` pulse, at cycle 16*(16+2+1)+1 after `start`.
- **Ties:** every SAD is 50 → `mv_x`=-2, `mv_y`=-2, `min_sad`=50.
- **Sequence:**
  - Count 256 `rd_en`, 16 `acc_clr` and 16 `cand_last`.
  - The first candidate's `ref_*` runs from (0,0) to (3,3); candidate 5 starts at `ref` (1,1).
  - `sad_valid` pulses injected during SCAN change nothing.
- **Mid-run reset:** assert `rst_n` low 40 cycles after `start` → `busy`=0 in the same cycle. A fresh `start` then reproduces the unique-minimum result.
- **`FSBM_EARLY_TERM_EN`:**
  - Feed `sad_part` = pixels so far × 10.
  - Same result as the unique-minimum scenario.
  - The `rd_en` count is below 256.
  - An aborted candidate is followed directly by `acc_clr`, with no WAIT.
